codificador_instr: RTL and testbench



---
 rtl/codificador_instr.sv | 136 +++++++++++++
 tb/tb_codificador_instr.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/codificador_instr.sv
// Instruction encoder/loader: packs class + register/immediate fields into 32-bit MIPS words
// and streams them into instruction memory from address 0. Optional funct screening: CODIF_CHECK_EN.
module codificador_instr #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_ANDI = 3'd2;
  localparam logic [2:0] OP_ORI  = 3'd3;
  localparam logic [2:0] OP_SLTI = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  function automatic logic [31:0] encode(
    input logic [2:0]  sel,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [5:0]  f_funct,
    input logic [15:0] f_imm
  );
    logic [5:0] opc;
    case (sel)
      OP_ADDI: opc = 6'b001000;
      OP_ANDI: opc = 6'b001100;
      OP_ORI:  opc = 6'b001101;
      OP_SLTI: opc = 6'b001010;
      OP_LW:   opc = 6'b100011;
      OP_SW:   opc = 6'b101011;
      OP_BEQ:  opc = 6'b000100;
      default: opc = 6'b000000;
    endcase
    if (sel == OP_R) begin
      encode = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, f_funct};
    end else begin
      encode = {opc, f_rs, f_rt, f_imm};
    end
  endfunction

`ifdef CODIF_CHECK_EN
  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  endfunction
`endif

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              full_s;
  logic              accept_s;
  logic              reject_s;

  assign full_s   = (count_q == DEPTH_C);
  assign in_ready = !full_s && !clr;
  assign accept_s = in_valid && in_ready;

`ifdef CODIF_CHECK_EN
  assign reject_s = accept_s && (op_sel == OP_R) && !funct_ok(funct);
`else
  assign reject_s = 1'b0;
`endif

  // Write-stage next state; clr wins over any handshake in the same cycle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    err_d     = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (accept_s && reject_s) begin
      err_d = 1'b1;
    end else if (accept_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q[ADDR_W-1:0];
      wr_data_d = encode(op_sel, rs, rt, rd, funct, imm);
      count_d   = count_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Write-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'h0000_0000;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign full    = full_s;
  assign err     = err_q;

endmodule

// File: tb/tb_codificador_instr.sv
// Directed self-checking bench for codificador_instr (DEPTH=4), expectations hand-encoded.
module tb_codificador_instr;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic              wr_en, full, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  codificador_instr #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] i);
    in_valid = 1'b1;
    op_sel = o; rs = a; rt = b; rd = d; funct = f; imm = i;
  endtask

  logic [2:0]  vec_op  [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
  logic [4:0]  vec_rs  [4] = '{5'd8, 5'd29, 5'd29, 5'd8};
  logic [15:0] vec_imm [4] = '{16'h0000, 16'h0004, 16'h0008, 16'hFFFF};
  logic [31:0] vec_exp [4] = '{32'h01095020, 32'h8FA90004, 32'hAFA90008, 32'h1109FFFF};

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    op_sel = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; funct = 6'd0; imm = 16'd0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);

    // ADDI after reset
    drive(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5);
    step();
    in_valid = 1'b0;
    chk("addi_wr_en", 32'(wr_en), 32'd1);
    chk("addi_wr_addr", 32'(wr_addr), 32'd0);
    chk("addi_wr_data", wr_data, 32'h20080005);
    chk("addi_count", 32'(count), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_wr_en", 32'(wr_en), 32'd0);

    // back-to-back fill, valid held 6 cycles
    for (int i = 0; i < 4; i++) begin
      drive(vec_op[i], vec_rs[i], 5'd9, 5'd10, 6'h20, vec_imm[i]);
      step();
      chk($sformatf("b2b%0d_wr_en", i), 32'(wr_en), 32'd1);
      chk($sformatf("b2b%0d_wr_addr", i), 32'(wr_addr), 32'(i));
      chk($sformatf("b2b%0d_wr_data", i), wr_data, vec_exp[i]);
      chk($sformatf("b2b%0d_count", i), 32'(count), 32'(i + 1));
    end
    chk("full_set", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("full%0d_wr_en", i), 32'(wr_en), 32'd0);
      chk($sformatf("full%0d_count", i), 32'(count), 32'd4);
      chk($sformatf("full%0d_wr_addr", i), 32'(wr_addr), 32'd3);
      chk($sformatf("full%0d_full", i), 32'(full), 32'd1);
    end

    // clr colliding with a handshake, 2 words loaded
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    drive(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0001);
    step();
    drive(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0002);
    step();
    chk("pre_clr_count", 32'(count), 32'd2);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("clrhs_wr_en", 32'(wr_en), 32'd0);
    chk("clrhs_count", 32'(count), 32'd0);
    chk("clrhs_wr_addr_hold", 32'(wr_addr), 32'd1);
    clr = 1'b0;
    drive(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h00FF);
    step();
    in_valid = 1'b0;
    chk("postclr_wr_addr", 32'(wr_addr), 32'd0);
    chk("postclr_wr_en", 32'(wr_en), 32'd1);
    chk("postclr_wr_data", wr_data, 32'h302200FF);

    // asynchronous reset while a write is on the port
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_wr_data", wr_data, 32'h0);
    step();
    rst_n = 1'b1;
    drive(3'd4, 5'd3, 5'd4, 5'd0, 6'd0, 16'h8000);
    step();
    in_valid = 1'b0;
    chk("postrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("postrst_wr_data", wr_data, 32'h28648000);
    chk("postrst_count", 32'(count), 32'd1);

    // R-type with an unlisted funct
    drive(3'd0, 5'd8, 5'd9, 5'd10, 6'h3F, 16'h0000);
    step();
    in_valid = 1'b0;
`ifdef CODIF_CHECK_EN
    chk("badf_err", 32'(err), 32'd1);
    chk("badf_wr_en", 32'(wr_en), 32'd0);
    chk("badf_count", 32'(count), 32'd1);
    step();
    chk("badf_err_pulse", 32'(err), 32'd0);
`else
    chk("badf_err", 32'(err), 32'd0);
    chk("badf_wr_en", 32'(wr_en), 32'd1);
    chk("badf_wr_addr", 32'(wr_addr), 32'd1);
    chk("badf_wr_data", wr_data, 32'h0109503F);
    chk("badf_count", 32'(count), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
